// File: rtl/wildcat_mem_arbiter_if.sv
// Bus bundle between the Wildcat fetch/LSU ports, the memory arbiter and the
// downstream memory port. The arbiter uses the slave view; the core/memory side uses master.
interface wildcat_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_ack;
    logic              d_rvalid;
    logic              d_err;

    logic [DATA_W-1:0] rdata;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              m_ack;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    logic              err_flag;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  m_ack, m_rvalid, m_rdata,
        output i_ack, i_rvalid, i_err, d_ack, d_rvalid, d_err, rdata,
        output m_req, m_we, m_addr, m_wdata, m_be, err_flag
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output m_ack, m_rvalid, m_rdata,
        input  i_ack, i_rvalid, i_err, d_ack, d_rvalid, d_err, rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be, err_flag
    );
endinterface

// File: rtl/wildcat_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and data (D),
// one transaction outstanding, with a response timeout that returns an error.
module wildcat_mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    wildcat_mem_arbiter_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    owner_e            sel_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic              err_flag_q, err_flag_d;
    logic              ack_c, rvalid_c, err_c;
    logic [DATA_W-1:0] rdata_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            cnt_q        <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_be_q       <= '0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_be_q       <= m_be_d;
            err_flag_q   <= err_flag_d;
        end
    end

    // Next-state, request latching and same-cycle ack/response routing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_be_d       = m_be_q;
        err_flag_d   = err_flag_q;
        sel_c        = OWN_I;
        ack_c        = 1'b0;
        rvalid_c     = 1'b0;
        err_c        = 1'b0;
        rdata_c      = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie, grant whoever did not win last time
                    sel_c = (bus.i_req && (!bus.d_req || last_owner_q == OWN_D)) ? OWN_I : OWN_D;
                    owner_d = sel_c;
                    m_req_d = 1'b1;
                    state_d = ST_REQ;
                    if (sel_c == OWN_I) begin
                        m_we_d    = 1'b0;
                        m_addr_d  = bus.i_addr;
                        m_wdata_d = '0;
                        m_be_d    = '1;
                    end else begin
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                        m_be_d    = bus.d_be;
                    end
                end
            end
            ST_REQ: begin
                if (bus.m_ack) begin
                    ack_c        = 1'b1;
                    m_req_d      = 1'b0;
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response wins over a timeout landing in the same cycle
                if (bus.m_rvalid) begin
                    rvalid_c = 1'b1;
                    rdata_c  = bus.m_rdata;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rvalid_c   = 1'b1;
                    err_c      = 1'b1;
                    err_flag_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.i_ack    = ack_c    && (owner_q == OWN_I);
    assign bus.d_ack    = ack_c    && (owner_q == OWN_D);
    assign bus.i_rvalid = rvalid_c && (owner_q == OWN_I);
    assign bus.d_rvalid = rvalid_c && (owner_q == OWN_D);
    assign bus.i_err    = err_c    && (owner_q == OWN_I);
    assign bus.d_err    = err_c    && (owner_q == OWN_D);
    assign bus.rdata    = rdata_c;
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_be     = m_be_q;
    assign bus.err_flag = err_flag_q;
endmodule
